// File: rtl/usb_cdc_bridge_pkg.sv
// Shared constants and types for the USB CDC register bridge.
// Opcodes, reply bytes and the command FSM state encoding.
package usb_cdc_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    RESP
  } bridge_state_t;

endpackage

// File: rtl/usb_cdc_reg_bridge_if.sv
// Byte-stream handshakes between the CDC core and the bridge.
// master = CDC side, slave = bridge side.
interface usb_cdc_reg_bridge_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/usb_cdc_bridge_regfile.sv
// Small 8-bit register file: one write port, one async read port.
// Whole array is also exported flattened, reg k at [8k+7:8k].
module usb_cdc_bridge_regfile #(
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [7:0]              wdata,
  input  logic [AW-1:0]           raddr,
  output logic [7:0]              rdata,
  output logic [8*NUM_REGS-1:0]   q
);

  logic [NUM_REGS-1:0][7:0] mem;

  // Register storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign q     = mem;

endmodule

// File: rtl/usb_cdc_reg_bridge.sv
// Command decoder for the CDC byte stream: W addr data / R addr.
// Holds the FSM, the mid-command timeout and the reply register.
module usb_cdc_reg_bridge
  import usb_cdc_bridge_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int IDLE_TIMEOUT = 48000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  usb_cdc_reg_bridge_if.slave   bus,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  err
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG8 = 8'(NUM_REGS);

  bridge_state_t state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_data_q, rsp;
  logic       tx_valid_q;
  logic       err_q, err_d;
  logic       we;
  logic [7:0] rdata;
  logic       accept;
  logic       wait_st;
  logic       timeout;

  assign bus.rx_ready = (state_q != RESP);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign err          = err_q;

  assign accept  = bus.rx_valid & bus.rx_ready;
  assign wait_st = (state_q == GET_ADDR) || (state_q == GET_DATA);

  usb_cdc_bridge_regfile #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (addr_q[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.rx_data[AW-1:0]),
    .rdata (rdata),
    .q     (reg_out)
  );

  generate
    if (IDLE_TIMEOUT > 0) begin : g_to
      localparam int TW = $clog2(IDLE_TIMEOUT + 1);
      localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT);
      logic [TW-1:0] cnt_q;

      // Saturating idle counter, only runs while mid-command.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (accept || !wait_st) begin
          cnt_q <= '0;
        end else if (cnt_q != TMAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign timeout = wait_st && (cnt_q == TMAX);
    end else begin : g_no_to
      assign timeout = 1'b0;
    end
  endgenerate

  // Next-state, reply byte, write strobe and error decode.
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    rsp     = tx_data_q;
    err_d   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.rx_data == OP_WRITE ||
              bus.rx_data == OP_READ) begin
            is_wr_d = (bus.rx_data == OP_WRITE);
            state_d = GET_ADDR;
          end else begin
            state_d = RESP;
            rsp     = RSP_ERR;
            err_d   = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (accept) begin
          addr_d = bus.rx_data;
          if (is_wr_q) begin
            state_d = GET_DATA;
          end else begin
            state_d = RESP;
            if (bus.rx_data < NREG8) begin
              rsp = rdata;
            end else begin
              rsp   = RSP_ERR;
              err_d = 1'b1;
            end
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_DATA: begin
        if (accept) begin
          state_d = RESP;
          if (addr_q < NREG8) begin
            we  = 1'b1;
            rsp = RSP_OK;
          end else begin
            rsp   = RSP_ERR;
            err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (tx_valid_q && bus.tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command latches and registered reply outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      tx_data_q  <= rsp;
      tx_valid_q <= (state_d == RESP);
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_usb_cdc_reg_bridge.sv
// Randomized bench for usb_cdc_reg_bridge against a command-level
// model of the register file and reply rules.
module tb_usb_cdc_reg_bridge;

  localparam int NR = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*NR-1:0] reg_out;
  logic err;

  int nchk = 0;
  int nerr = 0;
  int err_cnt = 0;
  logic [7:0] mdl [NR];

  usb_cdc_reg_bridge_if bus();

  usb_cdc_reg_bridge #(
    .NUM_REGS     (NR),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .reg_out (reg_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_cnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*NR-1:0] mdl_vec();
    logic [8*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[8*k +: 8] = mdl[k];
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("rx_wait", 0, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic get_reply(output logic [7:0] r);
    int n;
    n = 0;
    bus.tx_ready = 1'b1;
    while (!bus.tx_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("tx_wait", 0, 1);
    r = bus.tx_data;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] op,
                        input logic [7:0] a,
                        input logic [7:0] d);
    logic [7:0] exp, got;
    int e0, ee;
    e0 = err_cnt;
    ee = 0;
    if (op == 8'h57) begin
      if (a < NR) begin
        exp = 8'h4B;
        mdl[a[1:0]] = d;
      end else begin
        exp = 8'h3F;
        ee = 1;
      end
    end else if (op == 8'h52) begin
      if (a < NR) exp = mdl[a[1:0]];
      else begin
        exp = 8'h3F;
        ee = 1;
      end
    end else begin
      exp = 8'h3F;
      ee = 1;
    end
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      idle($urandom_range(0, 3));
      send_byte(a);
      if (op == 8'h57) begin
        idle($urandom_range(0, 3));
        send_byte(d);
      end
    end
    check("lat_valid", bus.tx_valid, 1);
    check("lat_data", bus.tx_data, exp);
    check("reg_out", reg_out, mdl_vec());
    idle($urandom_range(0, 3));
    get_reply(got);
    check("reply", got, exp);
    check("tx_drop", bus.tx_valid, 0);
    idle(1);
    check("err_cnt", err_cnt - e0, ee);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_txv"}, bus.tx_valid, 0);
    check({tag, "_txd"}, bus.tx_data, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_regs"}, reg_out, 0);
    check({tag, "_rdy"}, bus.rx_ready, 1);
  endtask

  initial begin
    logic [7:0] op, r, held;
    int n, e0;
    bit txv_seen;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    for (int k = 0; k < NR; k++) mdl[k] = 8'h00;

    #1;
    check_reset_vals("rst");
    idle(3);
    rst_n = 1'b1;
    idle(1);
    check_reset_vals("post_rst");

    do_cmd(8'h57, 8'h02, 8'hA5);
    check("reg2", reg_out[23:16], 8'hA5);
    do_cmd(8'h52, 8'h02, 8'h00);
    do_cmd(8'h52, 8'h00, 8'h00);
    do_cmd(8'h41, 8'h00, 8'h00);
    do_cmd(8'h57, 8'h07, 8'h11);
    do_cmd(8'h57, 8'h01, 8'h3C);
    do_cmd(8'h52, 8'h01, 8'h00);

    // Backpressure with a pending host byte.
    send_byte(8'h52);
    send_byte(8'h01);
    held = bus.tx_data;
    check("bp_data0", held, mdl[1]);
    bus.rx_data  = 8'h52;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.tx_valid, 1);
      check("bp_hold", bus.tx_data, held);
      check("bp_rdy", bus.rx_ready, 0);
      @(posedge clk); #1;
    end
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    check("bp_txv_fall", bus.tx_valid, 0);
    check("bp_rdy_rise", bus.rx_ready, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    send_byte(8'h01);
    get_reply(r);
    check("bp_next", r, mdl[1]);
    idle(1);

    // Mid-command timeout.
    mdl[1] = mdl[1];
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    n = 0;
    txv_seen = 0;
    while (err_cnt == e0 && n < 30) begin
      @(posedge clk); #1;
      if (bus.tx_valid) txv_seen = 1;
      n++;
    end
    check("to_err", err_cnt - e0, 1);
    check("to_span", (n >= TO && n <= TO + 2), 1);
    check("to_noreply", txv_seen, 0);
    idle(2);
    check("to_err_once", err_cnt - e0, 1);
    check("to_reg", reg_out, mdl_vec());
    do_cmd(8'h52, 8'h01, 8'h00);

    // Randomized command mix.
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      if (n < 4) op = 8'h57;
      else if (n < 8) op = 8'h52;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h57 || op == 8'h52) op = 8'h00;
      end
      do_cmd(op, 8'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)));
    end

    // Reset while waiting for the data byte.
    send_byte(8'h57);
    send_byte(8'h03);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_gd");
    for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(8'h57, 8'h03, 8'h77);

    // Reset while a reply is pending.
    send_byte(8'h52);
    send_byte(8'h03);
    check("rsp_pend", bus.tx_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("rst_rsp");
    for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) do_cmd(8'h52, 8'(k), 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
